command_sequencer: RTL and testbench

//  Line-buffer/sequencer in front of the 5-char command decoder. Accepts ASCII bytes from the UART

---
 rtl/command_sequencer_if.sv | 40 ++++
 rtl/command_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_command_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/command_sequencer_if.sv
// Handshake and command bus between the UART byte source, the command sequencer and
// the downstream decoder/datapath.
interface command_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [39:0] command;
    logic        cmd_valid;
    logic        exec_start;
    logic        exec_done;
    logic        busy;
    logic        error;
    logic [2:0]  char_count;

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  exec_done,
        output rx_ready,
        output command,
        output cmd_valid,
        output exec_start,
        output busy,
        output error,
        output char_count
    );

    modport master (
        output rx_data,
        output rx_valid,
        output exec_done,
        input  rx_ready,
        input  command,
        input  cmd_valid,
        input  exec_start,
        input  busy,
        input  error,
        input  char_count
    );
endinterface

// File: rtl/command_sequencer.sv
// Line buffer and sequencer ahead of the 5-char command decoder: edits a line from UART
// bytes, holds the submitted command stable, kicks the datapath and waits for completion.
//
// state       | meaning
// S_COLLECT   | accepting bytes, editing the line buffer
// S_HOLD      | command presented to decoder for HOLD_CYCLES
// S_EXEC      | one-cycle exec_start pulse
// S_WAIT_DONE | waiting for exec_done or timeout
// S_CLEAR     | one-cycle cleanup back to idle word and empty line
module command_sequencer #(
    parameter int HOLD_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int USE_DONE       = 1
) (
    input  logic                clk,
    input  logic                reset,
    command_sequencer_if.slave  bus
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES);

    localparam logic [7:0]  CH_SP  = 8'h20;
    localparam logic [7:0]  CH_CR  = 8'h0D;
    localparam logic [7:0]  CH_BS  = 8'h08;
    localparam logic [7:0]  CH_DEL = 8'h7F;
    localparam logic [7:0]  CH_TOP = 8'h7E;
    localparam logic [39:0] IDLE_WORD = {5{CH_SP}};
    localparam logic [2:0]  LINE_LEN  = 3'd5;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_HOLD,
        S_EXEC,
        S_WAIT_DONE,
        S_CLEAR
    } state_t;

    // Slot 0 is the first typed character and lands in command[39:32].
    typedef logic [0:4][7:0] line_t;

    state_t          state_q, state_n;
    line_t           line_q, line_n;
    logic [2:0]      count_q, count_n;
    logic            ovf_q, ovf_n;
    logic [HW-1:0]   hold_q, hold_n;
    logic [TW-1:0]   tmo_q, tmo_n;
    logic            err_n;
    logic            cmd_valid_n;

    logic            rx_ready_q;
    logic [39:0]     command_q;
    logic            cmd_valid_q;
    logic            exec_start_q;
    logic            busy_q;
    logic            error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_COLLECT;
        end else begin
            state_q <= state_n;
        end
    end

    always_comb begin
        state_n = state_q;
        line_n  = line_q;
        count_n = count_q;
        ovf_n   = ovf_q;
        hold_n  = hold_q;
        tmo_n   = tmo_q;
        err_n   = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (bus.rx_valid && rx_ready_q) begin
                    if (bus.rx_data == CH_CR) begin
                        // Unused slots are already spaces, so the line is ready as-is.
                        if (count_q != 3'd0) begin
                            if (ovf_q) begin
                                err_n   = 1'b1;
                                state_n = S_CLEAR;
                            end else begin
                                hold_n  = '0;
                                state_n = S_HOLD;
                            end
                        end
                    end else if (bus.rx_data == CH_BS || bus.rx_data == CH_DEL) begin
                        if (count_q != 3'd0) begin
                            line_n[count_q - 3'd1] = CH_SP;
                            count_n = count_q - 3'd1;
                        end
                    end else if (bus.rx_data >= CH_SP && bus.rx_data <= CH_TOP) begin
                        if (count_q < LINE_LEN) begin
                            line_n[count_q] = bus.rx_data;
                            count_n = count_q + 3'd1;
                        end else begin
                            ovf_n = 1'b1;
                        end
                    end
                end
            end

            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    hold_n  = '0;
                    state_n = S_EXEC;
                end else begin
                    hold_n = hold_q + HW'(1);
                end
            end

            S_EXEC: begin
                tmo_n   = '0;
                state_n = (USE_DONE != 0) ? S_WAIT_DONE : S_CLEAR;
            end

            S_WAIT_DONE: begin
                // Completion takes priority over a coincident expiry.
                if (bus.exec_done) begin
                    tmo_n   = '0;
                    state_n = S_CLEAR;
                end else if (tmo_q == TMO_LAST) begin
                    tmo_n   = '0;
                    err_n   = 1'b1;
                    state_n = S_CLEAR;
                end else if (tmo_q != TMO_MAX) begin
                    tmo_n = tmo_q + TW'(1);
                end
            end

            S_CLEAR: begin
                line_n  = {5{CH_SP}};
                count_n = 3'd0;
                ovf_n   = 1'b0;
                hold_n  = '0;
                tmo_n   = '0;
                state_n = S_COLLECT;
            end

            default: begin
                state_n = S_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q  <= {5{CH_SP}};
            count_q <= 3'd0;
            ovf_q   <= 1'b0;
            hold_q  <= '0;
            tmo_q   <= '0;
        end else begin
            line_q  <= line_n;
            count_q <= count_n;
            ovf_q   <= ovf_n;
            hold_q  <= hold_n;
            tmo_q   <= tmo_n;
        end
    end

    assign cmd_valid_n = (state_n == S_HOLD) || (state_n == S_EXEC) ||
                         (state_n == S_WAIT_DONE);

    // Outputs follow the next state so they are registered yet aligned with state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_ready_q   <= 1'b1;
            command_q    <= IDLE_WORD;
            cmd_valid_q  <= 1'b0;
            exec_start_q <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            rx_ready_q   <= (state_n == S_COLLECT);
            busy_q       <= (state_n != S_COLLECT);
            cmd_valid_q  <= cmd_valid_n;
            exec_start_q <= (state_n == S_EXEC);
            error_q      <= err_n;
            if (state_q == S_COLLECT && state_n == S_HOLD) begin
                command_q <= line_q;
            end else if (!cmd_valid_n) begin
                command_q <= IDLE_WORD;
            end
        end
    end

    assign bus.rx_ready   = rx_ready_q;
    assign bus.command    = command_q;
    assign bus.cmd_valid  = cmd_valid_q;
    assign bus.exec_start = exec_start_q;
    assign bus.busy       = busy_q;
    assign bus.error      = error_q;
    assign bus.char_count = count_q;

endmodule

// File: tb/tb_command_sequencer.sv
// Directed bench for command_sequencer: submitted lines are queued as expected commands
// and matched against the command bus when exec_start fires.
module tb_command_sequencer;

    localparam int          HOLD = 4;
    localparam int          TMO  = 16;
    localparam logic [39:0] IDLE = 40'h2020202020;
    localparam logic [7:0]  CR   = 8'h0D;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    command_sequencer_if bus();

    command_sequencer #(
        .HOLD_CYCLES    (HOLD),
        .TIMEOUT_CYCLES (TMO),
        .USE_DONE       (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails  = 0;
    logic [39:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".rx_ready"},   {39'd0, bus.rx_ready},   40'd1);
        check({tag, ".busy"},       {39'd0, bus.busy},       40'd0);
        check({tag, ".cmd_valid"},  {39'd0, bus.cmd_valid},  40'd0);
        check({tag, ".command"},    bus.command,             IDLE);
        check({tag, ".exec_start"}, {39'd0, bus.exec_start}, 40'd0);
        check({tag, ".error"},      {39'd0, bus.error},      40'd0);
        check({tag, ".char_count"}, {37'd0, bus.char_count}, 40'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        while (bus.rx_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("send.rx_ready", {39'd0, bus.rx_ready}, 40'd1);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            send_byte(s[i]);
        end
    endtask

    task automatic send_line(input string s, input logic [39:0] exp);
        send_str(s);
        exp_q.push_back(exp);
        send_byte(CR);
    endtask

    // Called right after CR is consumed; returns in the first cycle after the exec pulse.
    task automatic wait_exec(input string tag);
        int          n = 0;
        logic [39:0] exp;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : IDLE;
        while (bus.exec_start !== 1'b1 && n < 50) begin
            check({tag, ".hold_cmd"},   bus.command,            exp);
            check({tag, ".hold_valid"}, {39'd0, bus.cmd_valid}, 40'd1);
            tick();
            n++;
        end
        check({tag, ".exec_start"}, {39'd0, bus.exec_start}, 40'd1);
        check({tag, ".latency"},    40'(n),                  40'(HOLD));
        check({tag, ".exec_cmd"},   bus.command,             exp);
        tick();
        check({tag, ".pulse_end"},  {39'd0, bus.exec_start}, 40'd0);
        check({tag, ".wait_cmd"},   bus.command,             exp);
    endtask

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.exec_done = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        reset = 1'b0;
        tick();
        check_idle("post_reset");

        // 1: full five-char line, done three cycles after exec_start
        send_str("12+34");
        check("t1.count5", {37'd0, bus.char_count}, 40'd5);
        send_line("", 40'h31322B3334);
        wait_exec("t1");
        tick();
        tick();
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        check("t1.clr_cmd",   bus.command,            IDLE);
        check("t1.clr_valid", {39'd0, bus.cmd_valid}, 40'd0);
        check("t1.clr_ready", {39'd0, bus.rx_ready},  40'd0);
        check("t1.clr_err",   {39'd0, bus.error},     40'd0);
        tick();
        check_idle("t1.idle");

        // 2: short line padded, ignored control byte, turnaround latency
        send_str("he");
        send_byte(8'h01);
        check("t2.ctrl_ignored", {37'd0, bus.char_count}, 40'd2);
        send_str("y");
        check("t2.count3", {37'd0, bus.char_count}, 40'd3);
        send_line("", 40'h6865792020);
        wait_exec("t2");
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        check("t2.clear_not_ready", {39'd0, bus.rx_ready}, 40'd0);
        tick();
        check("t2.ready_again", {39'd0, bus.rx_ready}, 40'd1);

        // 3: backspace editing, both delete codes at count 0 are no-ops
        send_byte(8'h08);
        check("t3.bs_at_0", {37'd0, bus.char_count}, 40'd0);
        send_byte(8'h7F);
        check("t3.del_at_0", {37'd0, bus.char_count}, 40'd0);
        send_str("stx");
        send_byte(8'h08);
        check("t3.count_after_bs", {37'd0, bus.char_count}, 40'd2);
        send_line("op", 40'h73746F7020);
        wait_exec("t3");
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        tick();
        check_idle("t3.idle");

        // 4: overflowed line discarded with an error pulse
        send_str("hellox");
        check("t4.count_sat", {37'd0, bus.char_count}, 40'd5);
        send_byte(CR);
        check("t4.error",     {39'd0, bus.error},      40'd1);
        check("t4.no_exec",   {39'd0, bus.exec_start}, 40'd0);
        check("t4.cmd_idle",  bus.command,             IDLE);
        check("t4.no_valid",  {39'd0, bus.cmd_valid},  40'd0);
        tick();
        check_idle("t4.idle");

        // 5a: timeout after TMO cycles in WAIT_DONE
        send_line("t", 40'h7420202020);
        wait_exec("t5a");
        for (int i = 1; i < TMO; i++) begin
            tick();
            check("t5a.no_err_yet", {39'd0, bus.error},     40'd0);
            check("t5a.waiting",    {39'd0, bus.cmd_valid}, 40'd1);
        end
        tick();
        check("t5a.timeout_err", {39'd0, bus.error},     40'd1);
        check("t5a.cmd_idle",    bus.command,            IDLE);
        tick();
        check_idle("t5a.idle");

        // 5b: done coincident with expiry wins
        send_line("u", 40'h7520202020);
        wait_exec("t5b");
        for (int i = 1; i < TMO; i++) tick();
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        check("t5b.no_err",   {39'd0, bus.error},     40'd0);
        check("t5b.cleared",  {39'd0, bus.cmd_valid}, 40'd0);
        tick();
        check_idle("t5b.idle");

        // 6a: async reset in the middle of HOLD
        send_str("ab");
        send_byte(CR);
        check("t6a.in_hold", {39'd0, bus.cmd_valid}, 40'd1);
        tick();
        #2 reset = 1'b1;
        #1;
        check_idle("t6a.reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < HOLD + 2; i++) begin
            tick();
            check("t6a.no_exec", {39'd0, bus.exec_start}, 40'd0);
        end
        check_idle("t6a.idle");

        // 6b: async reset in the middle of WAIT_DONE suppresses the timeout
        send_line("w", 40'h7720202020);
        wait_exec("t6b");
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check_idle("t6b.reset");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < TMO + 2; i++) begin
            tick();
            check("t6b.no_err", {39'd0, bus.error}, 40'd0);
        end

        // 6c: byte held on rx_valid while busy is taken only once back in COLLECT
        send_line("q", 40'h7120202020);
        bus.rx_data  = "z";
        bus.rx_valid = 1'b1;
        wait_exec("t6c");
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        tick();
        check("t6c.ready",     {39'd0, bus.rx_ready},   40'd1);
        check("t6c.not_taken", {37'd0, bus.char_count}, 40'd0);
        tick();
        bus.rx_valid = 1'b0;
        check("t6c.taken",     {37'd0, bus.char_count}, 40'd1);
        send_line("", 40'h7A20202020);
        wait_exec("t6d");
        bus.exec_done = 1'b1;
        tick();
        bus.exec_done = 1'b0;
        tick();
        check_idle("t6d.idle");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
